alarm_keypad_ctrl: RTL
======================

# alarm_keypad_ctrl

- Code-entry front end for the security alarm panel.
- Collects BCD digits from a keypad scanner and checks them against a compiled-in user code.
- Drives the panel's command side: `arm` pulse, `disarm` pulse and `siren_en` level, which feeds the panel's alarm-on input.
- Enforces entry timeout and lockout after repeated bad codes.

## Interface
Parameters:
- `DIGITS`, 4 — code length in digits (1–8).
- `CODE`, 32'h0000_1234 — user code, BCD; low `DIGITS*4` bits used; first-entered digit is most significant.
- `TIMEOUT_CYCLES`, 1000 — idle cycles before a partial entry is discarded.
- `MAX_FAILS`, 3 — consecutive bad codes that trigger lockout.
- `LOCKOUT_CYCLES`, 5000 — lockout duration.

Ports:
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `key_valid` in 1 — one-cycle strobe; `key_code` is valid when high.
- `key_code` in 4 — 0–9 digit, 0xA ARM, 0xB DISARM, 0xC CLEAR, 0xD–0xF ignored.
- `arm` out 1 — one-cycle pulse to the panel.
- `disarm` out 1 — one-cycle pulse to the panel.
- `siren_en` out 1 — level; high from accepted ARM until accepted DISARM.
- `locked` out 1 — high during lockout.
- `fail` out 1 — one-cycle pulse on a rejected code.
- `duress` out 1 — one-cycle pulse; see Configuration.

## Operation
- Reset values: state IDLE; all outputs 0; digit count 0; fail count 0; timers 0.
- States:
  - IDLE: no digits held.
  - ENTRY: 1 or more digits held.
  - LOCKOUT: all keys ignored.
- Digit key: shifts into the entry register; count increments, saturating at `DIGITS`+1 (overflow flag).
  - IDLE→ENTRY on the first digit.
- CLEAR: discards the entry and goes to IDLE. Fail count is unchanged.
- ARM/DISARM in IDLE: ignored. No fail is counted.
- ARM/DISARM in ENTRY: the entry is a match only if count == `DIGITS` and the register == `CODE`. The state then returns to IDLE.
  - Match + ARM, `siren_en`=0: `arm` pulse, `siren_en`←1.
  - Match + DISARM, `siren_en`=1: `disarm` pulse, `siren_en`←0.
  - Match, command redundant for current `siren_en`: no pulse.
  - Any match clears the fail count.
  - Mismatch, including short or overflowed entry: `fail` pulse; fail count increments.
    - If the count reaches `MAX_FAILS`: go to LOCKOUT, `locked`←1, fail count←0.
- Timeout: in ENTRY, `TIMEOUT_CYCLES` consecutive cycles without `key_valid` → IDLE. The entry is discarded and no fail is counted. The timer restarts on every accepted key.
- LOCKOUT: the counter runs `LOCKOUT_CYCLES` cycles, then the state goes to IDLE and `locked`←0.
  - `siren_en` holds its value throughout lockout.
- Reset mid-entry or mid-lockout: returns to the reset values immediately, including `siren_en`=0.

## Timing
- `key_valid` is sampled on the rising edge of `clk`.
- Keys arriving on back-to-back cycles are all accepted.
- Command key sampled at edge N: `arm`/`disarm`/`fail`/`duress` are high for exactly the cycle after edge N+1's setup, i.e. registered, with 1-cycle latency. `siren_en` and `locked` change at the same edge.
- Pulses never exceed one cycle and are mutually exclusive, except that `disarm` and `duress` are high together.
- Timeout: the discard occurs on the edge at which the idle count equals `TIMEOUT_CYCLES`. A key on that same edge wins: it is processed and the timer restarts.
- Lockout: `locked` is high for exactly `LOCKOUT_CYCLES` cycles.
- Timer widths: `$clog2(max+1)`; counters saturate and never wrap.

## Configuration
- `KEYPAD_DURESS_EN` defined: the duress code is `CODE` with its last-entered digit incremented mod 10.
  - Duress code + DISARM with `siren_en`=1 → `disarm` and `duress` pulse in the same cycle; `siren_en`←0; fail count cleared.
  - Duress code + ARM is treated as a mismatch.
- `KEYPAD_DURESS_EN` undefined: `duress` is tied 0, and the duress code is an ordinary mismatch.

## Test plan
Bench parameters for all scenarios: `CODE`=16'h1234, `DIGITS`=4, `TIMEOUT_CYCLES`=20, `MAX_FAILS`=3, `LOCKOUT_CYCLES`=50.

- Keys 1,2,3,4,ARM → `arm`=1 for one cycle, one cycle after ARM; `siren_en`=1. Then 1,2,3,4,DISARM → `disarm` pulse, `siren_en`=0.
- Keys 1,2,3,5,ARM three times → `fail` pulses ×3; `locked`=1 for exactly 50 cycles. A correct code entered during lockout produces no `arm`. After unlock, 1,2,3,4,ARM arms.
- Keys 1,2 then 20 idle cycles, then 3,4,ARM → `fail` pulse, no `arm`, fail count 1.
- Keys 1,2,3,4,5,ARM (overflow) → `fail`. Keys 1,2,CLEAR,1,2,3,4,ARM → `arm`.
- Armed; keys 1,2,3,4,ARM → no pulse, `siren_en` stays 1. Assert `rst_n`=0 mid-entry → all outputs 0 asynchronously.
- With `KEYPAD_DURESS_EN`, armed; keys 1,2,3,5,DISARM → `disarm`=`duress`=1 in the same cycle. Without the macro, the same keys → `fail` only.

Source files
------------

// File: rtl/alarm_keypad_ctrl.sv
// rtl/alarm_keypad_ctrl.sv - keypad code-entry front end for the security alarm panel
//
// Collects BCD digits from the keypad scanner, checks them against the
// compiled-in user code and issues arm/disarm commands to the panel. Partial
// entries time out; repeated bad codes lock the keypad for a fixed period.
//
// Optional feature: define KEYPAD_DURESS_EN to accept a duress code (user code
// with its last-entered digit incremented mod 10) that disarms and raises duress.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   key_valid in   one-cycle key strobe
//   key_code  in   0-9 digit, A ARM, B DISARM, C CLEAR, D-F ignored
//   arm       out  one-cycle arm command pulse
//   disarm    out  one-cycle disarm command pulse
//   siren_en  out  level, high from accepted ARM until accepted DISARM
//   locked    out  high during lockout
//   fail      out  one-cycle pulse on a rejected code
//   duress    out  one-cycle pulse alongside disarm on a duress code
module alarm_keypad_ctrl #(
  parameter int unsigned DIGITS         = 4,
  parameter logic [31:0] CODE           = 32'h0000_1234,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       arm,
  output logic       disarm,
  output logic       siren_en,
  output logic       locked,
  output logic       fail,
  output logic       duress
);

  localparam int unsigned W      = DIGITS * 4;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 2);
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LCK_W  = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [W-1:0]      CODE_VAL  = CODE[W-1:0];
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIGITS + 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LCK_W-1:0]  LCK_LAST  = LCK_W'(LOCKOUT_CYCLES - 1);

`ifdef KEYPAD_DURESS_EN
  localparam logic [3:0]   LAST_DIGIT    = CODE[3:0];
  localparam logic [3:0]   DURESS_LAST   = (LAST_DIGIT >= 4'd9) ? 4'd0 : LAST_DIGIT + 4'd1;
  localparam logic [31:0]  DURESS_CODE32 = {CODE[31:4], DURESS_LAST};
  localparam logic [W-1:0] DURESS_VAL    = DURESS_CODE32[W-1:0];
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [W-1:0]        entry, entry_nxt;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [FAIL_W-1:0]   fail_cnt, fail_cnt_nxt;
  logic [TMO_W-1:0]    idle_cnt, idle_cnt_nxt;
  logic [LCK_W-1:0]    lock_cnt, lock_cnt_nxt;
  logic                siren_nxt;
  logic                arm_nxt, disarm_nxt, fail_nxt, duress_nxt;

  logic is_digit, is_arm, is_disarm, is_clear;
  logic match, duress_match;

  assign is_digit  = (key_code <= 4'd9);
  assign is_arm    = (key_code == 4'hA);
  assign is_disarm = (key_code == 4'hB);
  assign is_clear  = (key_code == 4'hC);

  // An overflowed entry has count DIGITS+1, so it can never match.
  assign match = (count == CNT_FULL) && (entry == CODE_VAL);

`ifdef KEYPAD_DURESS_EN
  assign duress_match = (count == CNT_FULL) && (entry == DURESS_VAL);
`else
  assign duress_match = 1'b0;
`endif

  assign locked = (state == LOCKOUT);

  always_comb begin
    state_nxt    = state;
    entry_nxt    = entry;
    count_nxt    = count;
    fail_cnt_nxt = fail_cnt;
    idle_cnt_nxt = idle_cnt;
    lock_cnt_nxt = lock_cnt;
    siren_nxt    = siren_en;
    arm_nxt      = 1'b0;
    disarm_nxt   = 1'b0;
    fail_nxt     = 1'b0;
    duress_nxt   = 1'b0;

    case (state)
      IDLE: begin
        // Commands and CLEAR with nothing entered are silently ignored.
        if (key_valid && is_digit) begin
          state_nxt    = ENTRY;
          entry_nxt    = W'(key_code);
          count_nxt    = CNT_W'(1);
          idle_cnt_nxt = '0;
        end
      end

      ENTRY: begin
        if (key_valid) begin
          // Any key strobe, even an ignored code, counts as activity.
          idle_cnt_nxt = '0;
          if (is_digit) begin
            entry_nxt = (entry << 4) | W'(key_code);
            if (count != CNT_MAX) count_nxt = count + CNT_W'(1);
          end else if (is_clear) begin
            state_nxt = IDLE;
            entry_nxt = '0;
            count_nxt = '0;
          end else if (is_arm || is_disarm) begin
            state_nxt = IDLE;
            entry_nxt = '0;
            count_nxt = '0;
            if (match) begin
              fail_cnt_nxt = '0;
              if (is_arm && !siren_en) begin
                arm_nxt   = 1'b1;
                siren_nxt = 1'b1;
              end else if (is_disarm && siren_en) begin
                disarm_nxt = 1'b1;
                siren_nxt  = 1'b0;
              end
            end else if (duress_match && is_disarm) begin
              // Looks like a normal disarm to an onlooker; duress flags it upstream.
              fail_cnt_nxt = '0;
              if (siren_en) begin
                disarm_nxt = 1'b1;
                duress_nxt = 1'b1;
                siren_nxt  = 1'b0;
              end
            end else begin
              fail_nxt = 1'b1;
              if (fail_cnt == FAIL_LAST) begin
                state_nxt    = LOCKOUT;
                fail_cnt_nxt = '0;
                lock_cnt_nxt = '0;
              end else begin
                fail_cnt_nxt = fail_cnt + FAIL_W'(1);
              end
            end
          end
        end else begin
          // Discard on the TIMEOUT_CYCLES-th consecutive keyless edge.
          if (idle_cnt == TMO_LAST) begin
            state_nxt    = IDLE;
            entry_nxt    = '0;
            count_nxt    = '0;
            idle_cnt_nxt = '0;
          end else begin
            idle_cnt_nxt = idle_cnt + TMO_W'(1);
          end
        end
      end

      LOCKOUT: begin
        // locked is high from the entering edge through LOCKOUT_CYCLES cycles.
        if (lock_cnt == LCK_LAST) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + LCK_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        entry_nxt = '0;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      entry    <= '0;
      count    <= '0;
      fail_cnt <= '0;
      idle_cnt <= '0;
      lock_cnt <= '0;
      siren_en <= 1'b0;
      arm      <= 1'b0;
      disarm   <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state    <= state_nxt;
      entry    <= entry_nxt;
      count    <= count_nxt;
      fail_cnt <= fail_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
      lock_cnt <= lock_cnt_nxt;
      siren_en <= siren_nxt;
      arm      <= arm_nxt;
      disarm   <= disarm_nxt;
      fail     <= fail_nxt;
    end
  end

`ifdef KEYPAD_DURESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duress <= 1'b0;
    else        duress <= duress_nxt;
  end
`else
  assign duress = 1'b0;
  logic unused_duress;
  assign unused_duress = duress_nxt;
`endif

endmodule
